// File: rtl/sudoku_onehot_stream.sv
// Sudoku row decoder: packed cell codes to one-hot digits, through a 2-entry output FIFO.
// Optional duplicate-digit flag enabled by defining SUDOKU_DUP_CHECK_EN.
module sudoku_onehot_stream #(
   parameter int unsigned N  = 9,
   parameter int unsigned CW = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N*CW-1:0]           in_code,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N*N-1:0]            out_onehot,
   output logic [N-1:0]              out_err,
   output logic [$clog2(N)-1:0]      out_row,
   output logic                      out_last,
   output logic                      out_frame_err,
   output logic                      out_dup
);

   localparam int unsigned RW = $clog2(N);

   typedef struct packed {
      logic [N*N-1:0] onehot;
      logic [N-1:0]   err;
      logic [RW-1:0]  row;
      logic           last;
      logic           ferr;
      logic           dup;
   } entry_t;

   entry_t        head_q, head_d, tail_q, tail_d, dec;
   logic          head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
   logic [RW-1:0] row_q, row_d;
   logic          acc_q, acc_d;
   logic [N*N-1:0] dec_oh;
   logic [N-1:0]   dec_err;
   logic           dup_in;
   logic           push, pop, last_in;

   always_comb begin
      logic [CW-1:0] code;
      dec_oh  = '0;
      dec_err = '0;
      for (int unsigned c = 0; c < N; c++) begin
         code = in_code[c*CW +: CW];
         if (code > CW'(N)) dec_err[c] = 1'b1;
         for (int unsigned k = 1; k <= N; k++) begin
            if (code == CW'(k)) dec_oh[c*N + k - 1] = 1'b1;
         end
      end
   end

`ifdef SUDOKU_DUP_CHECK_EN
   // A digit already seen in an earlier cell of the row flags a duplicate.
   always_comb begin
      logic [N-1:0] seen;
      seen   = '0;
      dup_in = 1'b0;
      for (int unsigned c = 0; c < N; c++) begin
         dup_in = dup_in | (|(seen & dec_oh[c*N +: N]));
         seen   = seen | dec_oh[c*N +: N];
      end
   end
`else
   assign dup_in = 1'b0;
`endif

   assign last_in = (row_q == RW'(N - 1));
   assign push    = in_valid && !tail_vld_q;
   assign pop     = head_vld_q && out_ready;

   always_comb begin
      dec.onehot = dec_oh;
      dec.err    = dec_err;
      dec.row    = row_q;
      dec.last   = last_in;
      dec.ferr   = last_in && (acc_q || (|dec_err));
      dec.dup    = dup_in;

      head_d     = head_q;
      tail_d     = tail_q;
      head_vld_d = head_vld_q;
      tail_vld_d = tail_vld_q;
      row_d      = row_q;
      acc_d      = acc_q;

      if (push) begin
         row_d = last_in ? '0 : row_q + RW'(1);
         acc_d = last_in ? 1'b0 : (acc_q || (|dec_err));
      end

      // Push is impossible while the tail is occupied, so a full FIFO only drains.
      if (tail_vld_q) begin
         if (pop) begin
            head_d     = tail_q;
            tail_vld_d = 1'b0;
         end
      end else if (head_vld_q) begin
         if (pop && push) begin
            head_d = dec;
         end else if (pop) begin
            head_vld_d = 1'b0;
         end else if (push) begin
            tail_d     = dec;
            tail_vld_d = 1'b1;
         end
      end else if (push) begin
         head_d     = dec;
         head_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         head_vld_q <= 1'b0;
         tail_vld_q <= 1'b0;
         row_q      <= '0;
         acc_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         head_vld_q <= head_vld_d;
         tail_vld_q <= tail_vld_d;
         row_q      <= row_d;
         acc_q      <= acc_d;
      end
   end

   assign in_ready      = !tail_vld_q;
   assign out_valid     = head_vld_q;
   assign out_onehot    = head_q.onehot;
   assign out_err       = head_q.err;
   assign out_row       = head_q.row;
   assign out_last      = head_q.last;
   assign out_frame_err = head_q.ferr;
   assign out_dup       = head_q.dup;

endmodule

// File: tb/tb_sudoku_onehot_stream.sv
// Directed bench for sudoku_onehot_stream (N=9, CW=4): vector table plus stall and reset sequences.
module tb_sudoku_onehot_stream;

   localparam int N  = 9;
   localparam int CW = 4;
`ifdef SUDOKU_DUP_CHECK_EN
   localparam bit DupEn = 1'b1;
`else
   localparam bit DupEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [N*CW-1:0]   in_code;
   logic [N*N-1:0]    out_onehot;
   logic [N-1:0]      out_err;
   logic [3:0]        out_row;
   logic              out_last, out_frame_err, out_dup;

   sudoku_onehot_stream #(.N(N), .CW(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_code       (in_code),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_onehot    (out_onehot),
      .out_err       (out_err),
      .out_row       (out_row),
      .out_last      (out_last),
      .out_frame_err (out_frame_err),
      .out_dup       (out_dup)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [35:0] code;
      logic [80:0] oh;
      logic [8:0]  err;
      logic        dup;
   } vec_t;

   vec_t vecs [9];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int       exp_row;
      logic     acc, last, eferr;
      int       nsent, nrecv;
      logic [35:0] code;

      in_valid  = 1'b0;
      in_code   = '0;
      out_ready = 1'b1;

      // cells listed high to low: {c8,...,c0}
      vecs[0] = '{code: 36'h987654321,
                  oh: {9'h100, 9'h080, 9'h040, 9'h020, 9'h010, 9'h008, 9'h004, 9'h002, 9'h001},
                  err: 9'h000, dup: 1'b0};
      vecs[1] = '{code: 36'h4321FA980,
                  oh: {9'h008, 9'h004, 9'h002, 9'h001, 9'h000, 9'h000, 9'h100, 9'h080, 9'h000},
                  err: 9'h018, dup: 1'b0};
      vecs[2] = '{code: 36'h000000033,
                  oh: {9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h004, 9'h004},
                  err: 9'h000, dup: 1'b1};
      vecs[3] = '{code: 36'h000000000, oh: '0, err: 9'h000, dup: 1'b0};
      vecs[4] = '{code: 36'h123456789,
                  oh: {9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h100},
                  err: 9'h000, dup: 1'b0};
      vecs[5] = '{code: 36'hAAAAAAAAA, oh: '0, err: 9'h1FF, dup: 1'b0};
      vecs[6] = '{code: 36'h555555555,
                  oh: {9'h010, 9'h010, 9'h010, 9'h010, 9'h010, 9'h010, 9'h010, 9'h010, 9'h010},
                  err: 9'h000, dup: 1'b1};
      vecs[7] = '{code: 36'h900000002,
                  oh: {9'h100, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h002},
                  err: 9'h000, dup: 1'b0};
      vecs[8] = vecs[0];

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_onehot", out_onehot, '0);
      chk("rst_err", out_err, '0);
      chk("rst_row", out_row, '0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_frame_err", out_frame_err, 1'b0);
      chk("rst_dup", out_dup, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Table: one beat per cycle, occupancy stays at one
      exp_row = 0;
      acc = 1'b0;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_code  = vecs[i].code;
         chk("tbl_in_ready", in_ready, 1'b1);
         step();
         in_valid = 1'b0;
         last  = (exp_row == 8);
         acc   = acc | (|vecs[i].err);
         eferr = last ? acc : 1'b0;
         if (last) acc = 1'b0;
         chk("tbl_out_valid", out_valid, 1'b1);
         chk("tbl_onehot", out_onehot, vecs[i].oh);
         chk("tbl_err", out_err, vecs[i].err);
         chk("tbl_row", out_row, exp_row);
         chk("tbl_last", out_last, last);
         chk("tbl_frame_err", out_frame_err, eferr);
         chk("tbl_dup", out_dup, vecs[i].dup & DupEn);
         exp_row = last ? 0 : exp_row + 1;
      end
      step();
      chk("drain_empty", out_valid, 1'b0);

      // Clean frame, then frame with code 0xC in row 5
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < 9; r++) begin
            in_valid = 1'b1;
            in_code  = (f == 1 && r == 5) ? 36'h98765432C : 36'h987654321;
            step();
            in_valid = 1'b0;
            if (f == 1 && r == 5) chk("frame_row5_err", out_err, 9'h001);
            if (r == 8) begin
               chk("frame_last", out_last, 1'b1);
               chk("frame_err", out_frame_err, f[0]);
            end else begin
               chk("frame_not_last_ferr", out_frame_err, 1'b0);
            end
         end
      end
      step();

      // Backpressure: 4 stalled cycles, then drain in order
      out_ready = 1'b0;
      nsent = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         in_valid = 1'b1;
         in_code  = {32'h0, 4'(nsent + 1)};
         chk("stall_in_ready", in_ready, (cyc < 2));
         if (in_ready) nsent++;
         step();
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_hold", out_onehot[8:0], 9'h001);
      end
      chk("stall_accepts", nsent, 2);
      out_ready = 1'b1;
      nrecv = 0;
      for (int t = 0; t < 20 && nrecv < 4; t++) begin
         if (nsent < 4) begin
            in_valid = 1'b1;
            in_code  = {32'h0, 4'(nsent + 1)};
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            chk("order", out_onehot[8:0], 9'(1 << nrecv));
            nrecv++;
         end
         if (in_valid && in_ready) nsent++;
         step();
      end
      in_valid = 1'b0;
      chk("recv_count", nrecv, 4);
      step();
      chk("recv_empty", out_valid, 1'b0);

      // Row counter now at 4; hold that beat, then reset mid-frame
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 36'h987654321;
      step();
      in_valid = 1'b0;
      chk("pre_rst_row", out_row, 4);
      chk("pre_rst_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_onehot", out_onehot, '0);
      chk("mid_rst_row", out_row, '0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      code      = 36'h000000033;
      in_code   = code;
      step();
      in_valid = 1'b0;
      chk("post_rst_valid", out_valid, 1'b1);
      chk("post_rst_row", out_row, 0);
      chk("post_rst_dup", out_dup, DupEn);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
